// File: rtl/pc_gen_pkg.sv
// ---------------------------------------------------------------------------
// pc_gen_pkg
// Shared definitions for the fetch PC generator:
//   - redir_sel_e   : encoding of the redirect target select
//   - DEF_RESET_PC  : default PC loaded by reset
//   - DEF_EXC_VEC   : default exception handler entry
// ---------------------------------------------------------------------------
package pc_gen_pkg;

    typedef enum logic [1:0] {
        SEL_B    = 2'd0,
        SEL_J    = 2'd1,
        SEL_JR   = 2'd2,
        SEL_ERET = 2'd3
    } redir_sel_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/npc_tgt_sel.sv
// ---------------------------------------------------------------------------
// npc_tgt_sel
// Purely combinational redirect target multiplexer.
// Ports:
//   redir_sel : 2-bit target select (see pc_gen_pkg::redir_sel_e)
//   b_tgt     : branch target
//   j_tgt     : jump target
//   jr_tgt    : jump-register target
//   epc       : exception return target
//   tgt       : selected target
// ---------------------------------------------------------------------------
module npc_tgt_sel
    import pc_gen_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [1:0]   redir_sel,
    input  logic [W-1:0] b_tgt,
    input  logic [W-1:0] j_tgt,
    input  logic [W-1:0] jr_tgt,
    input  logic [W-1:0] epc,
    output logic [W-1:0] tgt
);

    // Pick one of the four candidate targets. Every encoding of the 2-bit
    // select is meaningful, so the branch default is only a safe fallback.
    always_comb begin
        tgt = b_tgt;
        case (redir_sel_e'(redir_sel))
            SEL_B:    tgt = b_tgt;
            SEL_J:    tgt = j_tgt;
            SEL_JR:   tgt = jr_tgt;
            SEL_ERET: tgt = epc;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Fetch program counter generator with a one-entry pending redirect buffer.
// A redirect that arrives while fetch is stalled is remembered and applied on
// the first unstalled edge, unless a newer redirect or an exception wins.
// Parameters:
//   W        : PC / target width (intended range 8..64)
//   RESET_PC : PC after reset
//   EXC_VEC  : exception handler entry
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   stall               : hold the fetch PC this cycle
//   exc                 : exception request, redirect to EXC_VEC
//   redir_valid         : control-flow redirect request
//   redir_sel           : 0 branch, 1 jump, 2 jr, 3 eret
//   b_tgt/j_tgt/jr_tgt/epc : candidate targets
//   pc                  : registered fetch PC
//   pc4, pc8            : pc+4 and pc+8, modulo 2^W
//   redir_pending       : registered, a buffered redirect is waiting
//   pc_misalign         : pc is not word aligned
// ---------------------------------------------------------------------------
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int           W        = 32,
    parameter logic [W-1:0] RESET_PC = W'(DEF_RESET_PC),
    parameter logic [W-1:0] EXC_VEC  = W'(DEF_EXC_VEC)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         exc,
    input  logic         redir_valid,
    input  logic [1:0]   redir_sel,
    input  logic [W-1:0] b_tgt,
    input  logic [W-1:0] j_tgt,
    input  logic [W-1:0] jr_tgt,
    input  logic [W-1:0] epc,
    output logic [W-1:0] pc,
    output logic [W-1:0] pc4,
    output logic [W-1:0] pc8,
    output logic         redir_pending,
    output logic         pc_misalign
);

    logic [W-1:0] sel_tgt;
    logic [W-1:0] pend_tgt;

    npc_tgt_sel #(.W(W)) u_tgt_sel (
        .redir_sel (redir_sel),
        .b_tgt     (b_tgt),
        .j_tgt     (j_tgt),
        .jr_tgt    (jr_tgt),
        .epc       (epc),
        .tgt       (sel_tgt)
    );

    // Sequential increments wrap silently at 2^W; misaligned PCs are only
    // flagged, never trapped here.
    assign pc4         = pc + W'(4);
    assign pc8         = pc + W'(8);
    assign pc_misalign = (pc[1:0] != 2'b00);

    // PC register and pending buffer. Priority: reset, exception, stall
    // (which may capture a redirect into the buffer, newest wins), a live
    // redirect (which also drops any older buffered one), the buffered
    // redirect, then plain sequential fetch. Only registers feed pc and
    // redir_pending, so control inputs never reach them combinationally.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            redir_pending <= 1'b0;
            pend_tgt      <= '0;
        end else if (exc) begin
            pc            <= EXC_VEC;
            redir_pending <= 1'b0;
        end else if (stall) begin
            if (redir_valid) begin
                pend_tgt      <= sel_tgt;
                redir_pending <= 1'b1;
            end
        end else if (redir_valid) begin
            pc            <= sel_tgt;
            redir_pending <= 1'b0;
        end else if (redir_pending) begin
            pc            <= pend_tgt;
            redir_pending <= 1'b0;
        end else begin
            pc <= pc4;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen
// Scoreboard bench for pc_gen: a 32-bit instance with default parameters and
// an 8-bit instance for wrap-around. Stimulus pushes hand-computed expected
// pc / redir_pending after each edge; a monitor pops and compares on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk = 1'b0;

    logic        reset, stall, exc, redir_valid;
    logic [1:0]  redir_sel;
    logic [31:0] b_tgt, j_tgt, jr_tgt, epc;
    logic [31:0] pc, pc4, pc8;
    logic        redir_pending, pc_misalign;

    logic        reset8, stall8, exc8, redir_valid8;
    logic [1:0]  redir_sel8;
    logic [7:0]  b_tgt8, j_tgt8, jr_tgt8, epc8;
    logic [7:0]  pc_8, pc4_8, pc8_8;
    logic        redir_pending8, pc_misalign8;

    typedef struct {
        string       name;
        bit          is8;
        logic [31:0] pc;
        logic        pend;
    } exp_t;

    exp_t sb[$];
    int   tests    = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .exc           (exc),
        .redir_valid   (redir_valid),
        .redir_sel     (redir_sel),
        .b_tgt         (b_tgt),
        .j_tgt         (j_tgt),
        .jr_tgt        (jr_tgt),
        .epc           (epc),
        .pc            (pc),
        .pc4           (pc4),
        .pc8           (pc8),
        .redir_pending (redir_pending),
        .pc_misalign   (pc_misalign)
    );

    pc_gen #(.W(8)) dut8 (
        .clk           (clk),
        .reset         (reset8),
        .stall         (stall8),
        .exc           (exc8),
        .redir_valid   (redir_valid8),
        .redir_sel     (redir_sel8),
        .b_tgt         (b_tgt8),
        .j_tgt         (j_tgt8),
        .jr_tgt        (jr_tgt8),
        .epc           (epc8),
        .pc            (pc_8),
        .pc4           (pc4_8),
        .pc8           (pc8_8),
        .redir_pending (redir_pending8),
        .pc_misalign   (pc_misalign8)
    );

    // Drive one cycle of inputs on the chosen instance, let the edge happen,
    // then queue what that instance must show afterwards.
    task automatic applyStimulus(input string name, input bit is8,
                                 input logic rs, input logic ex, input logic st,
                                 input logic rv, input logic [1:0] sel,
                                 input logic [31:0] b, input logic [31:0] j,
                                 input logic [31:0] jr, input logic [31:0] e,
                                 input logic [31:0] exp_pc, input logic exp_pend);
        exp_t item;
        if (is8) begin
            reset8 = rs; exc8 = ex; stall8 = st; redir_valid8 = rv; redir_sel8 = sel;
            b_tgt8 = b[7:0]; j_tgt8 = j[7:0]; jr_tgt8 = jr[7:0]; epc8 = e[7:0];
        end else begin
            reset = rs; exc = ex; stall = st; redir_valid = rv; redir_sel = sel;
            b_tgt = b; j_tgt = j; jr_tgt = jr; epc = e;
        end
        @(posedge clk);
        #1;
        item.name = name;
        item.is8  = is8;
        item.pc   = exp_pc;
        item.pend = exp_pend;
        sb.push_back(item);
    endtask

    task automatic compare(input string name, input logic [31:0] act,
                           input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // pc4/pc8/misalign expectations are derived from the expected pc.
    task automatic checkOutput(input exp_t e);
        logic [31:0] mask, a_pc, a_pc4, a_pc8;
        logic        a_pend, a_mis;
        mask = e.is8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
        if (e.is8) begin
            a_pc = {24'h0, pc_8}; a_pc4 = {24'h0, pc4_8}; a_pc8 = {24'h0, pc8_8};
            a_pend = redir_pending8; a_mis = pc_misalign8;
        end else begin
            a_pc = pc; a_pc4 = pc4; a_pc8 = pc8;
            a_pend = redir_pending; a_mis = pc_misalign;
        end
        compare({e.name, ".pc"},   a_pc,  e.pc & mask);
        compare({e.name, ".pc4"},  a_pc4, (e.pc + 32'd4) & mask);
        compare({e.name, ".pc8"},  a_pc8, (e.pc + 32'd8) & mask);
        compare({e.name, ".pend"}, {31'h0, a_pend}, {31'h0, e.pend});
        compare({e.name, ".mis"},  {31'h0, a_mis},  {31'h0, (e.pc[1:0] != 2'b00)});
    endtask

    // Monitor: every falling edge, check the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    localparam logic [31:0] X0 = 32'h0000_1110;
    localparam logic [31:0] X1 = 32'h0000_2220;
    localparam logic [31:0] X2 = 32'h0000_3330;
    localparam logic [31:0] X3 = 32'h0000_5550;

    initial begin
        reset8 = 1'b1; exc8 = 0; stall8 = 0; redir_valid8 = 0; redir_sel8 = 0;
        b_tgt8 = 0; j_tgt8 = 0; jr_tgt8 = 0; epc8 = 0;

        // Reset and sequential fetch
        applyStimulus("reset", 0, 1,0,0,0,2'd0, X0,X1,X2,X3, 32'h3000, 0);
        applyStimulus("idle1", 0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h3004, 0);
        applyStimulus("idle2", 0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h3008, 0);
        applyStimulus("idle3", 0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h300C, 0);

        // Stalled jump held for two cycles, then released
        applyStimulus("stj1",  0, 0,0,1,1,2'd1, X0,32'h3100,X2,X3, 32'h300C, 1);
        applyStimulus("stj2",  0, 0,0,1,1,2'd1, X0,32'h3100,X2,X3, 32'h300C, 1);
        applyStimulus("relj",  0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h3100, 0);
        applyStimulus("seqj",  0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h3104, 0);

        // Two stalled redirects: the newer one wins
        applyStimulus("stjr",  0, 0,0,1,1,2'd2, X0,X1,32'h3200,X3, 32'h3104, 1);
        applyStimulus("stb",   0, 0,0,1,1,2'd0, 32'h3300,X1,X2,X3, 32'h3104, 1);
        applyStimulus("relb",  0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h3300, 0);

        // Exception beats stall, redirect and pending
        applyStimulus("stj3",  0, 0,0,1,1,2'd1, X0,32'h3100,X2,X3, 32'h3300, 1);
        applyStimulus("exc",   0, 0,1,1,1,2'd1, X0,32'h3100,X2,X3, 32'h4180, 0);
        applyStimulus("pexc",  0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h4184, 0);

        // Live redirect overrides and clears an older pending one
        applyStimulus("ster",  0, 0,0,1,1,2'd3, X0,X1,X2,32'h5000, 32'h4184, 1);
        applyStimulus("live",  0, 0,0,0,1,2'd0, 32'h6000,X1,X2,X3, 32'h6000, 0);
        applyStimulus("plive", 0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h6004, 0);

        // Reset discards a pending redirect and beats exception
        applyStimulus("stjr2", 0, 0,0,1,1,2'd2, X0,X1,32'h3200,X3, 32'h6004, 1);
        applyStimulus("rstp",  0, 1,1,0,0,2'd0, X0,X1,X2,X3, 32'h3000, 0);
        applyStimulus("prst",  0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h3004, 0);

        // Misaligned target is loaded as-is and flagged
        applyStimulus("misjr", 0, 0,0,0,1,2'd2, X0,X1,32'h3002,X3, 32'h3002, 0);
        applyStimulus("misq",  0, 0,0,0,0,2'd0, X0,X1,X2,X3, 32'h3006, 0);

        // 8-bit instance: wrap-around of pc+4
        applyStimulus("w8rst", 1, 1,0,0,0,2'd0, 0,0,0,0, 32'h00, 0);
        applyStimulus("w8j",   1, 0,0,0,1,2'd1, 32'h11,32'hFC,32'h22,32'h33, 32'hFC, 0);
        applyStimulus("w8wrap",1, 0,0,0,0,2'd0, 0,0,0,0, 32'h00, 0);
        applyStimulus("w8exc", 1, 0,1,0,0,2'd0, 0,0,0,0, 32'h80, 0);

        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
